// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared defaults and state encoding for the bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit-counter width; a one-bit operand still needs a one-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_fulladder.sv
`default_nettype none
// ============================================================================
// Module      : fulladder
// Description : One-bit full-adder cell shared by the serial datapaths.
// Revision    : 1.0 - initial release
// ============================================================================
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder, LSB first, one full-adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                  c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   rega_q, rega_d;
    logic [WIDTH-1:0]   regb_q, regb_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               w_fa_sum;
    logic               w_fa_carry;

    fulladder u_fa (
        .a     (rega_q[0]),
        .b     (regb_q[0]),
        .c     (carry_q),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rega_d  = rega_q;
        regb_d  = regb_q;
        psum_d  = psum_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    rega_d  = a;
                    regb_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                psum_d            = psum_q >> 1;
                psum_d[WIDTH-1]   = w_fa_sum;
                rega_d            = rega_q >> 1;
                regb_d            = regb_q >> 1;
                carry_d           = w_fa_carry;
                cnt_d             = cnt_q + c_cnt_w'(1);
                if (cnt_q == c_last) begin
                    sum_d   = psum_d;
                    cout_d  = w_fa_carry;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rega_q  <= '0;
            regb_q  <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rega_q  <= rega_d;
            regb_q  <= regb_d;
            psum_q  <= psum_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Scoreboard bench for serial_adder at WIDTH 8, 1 and 32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8 instance (scoreboarded)
    logic       s8, c8, r8, bz8, d8, co8;
    logic [7:0] a8, b8, sum8;
    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .cin(c8),
        .ready(r8), .busy(bz8), .done(d8), .sum(sum8), .cout(co8));

    // WIDTH=1 instance
    logic s1, a1, b1, c1, r1, bz1, d1, co1;
    logic [0:0] sum1;
    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .cin(c1),
        .ready(r1), .busy(bz1), .done(d1), .sum(sum1), .cout(co1));

    // WIDTH=32 instance
    logic        s32, c32, r32, bz32, d32, co32;
    logic [31:0] a32, b32, sum32;
    serial_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(s32), .a(a32), .b(b32), .cin(c32),
        .ready(r32), .busy(bz32), .done(d32), .sum(sum32), .cout(co32));

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         due;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && d8) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {63'b0, d8}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.due);
                chk("sum", {56'b0, sum8}, {56'b0, e.sum});
                chk("cout", {63'b0, co8}, {63'b0, e.cout});
            end
        end
    end

    // Drives start for one cycle and records the expected result due WIDTH+1 later.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] esum, input logic ecout);
        @(negedge clk);
        a8 = a; b8 = b; c8 = c; s8 = 1'b1;
        sb.push_back('{esum, ecout, cyc + 9});
        @(negedge clk);
        s8 = 1'b0;
    endtask

    task automatic drain(input int max);
        int k;
        k = 0;
        while (sb.size() != 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    logic [1:0]  exp1  [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [31:0] a32v  [3] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000};
    logic [31:0] b32v  [3] = '{32'h0000_0001, 32'h8765_4321, 32'h7FFF_FFFF};
    logic        c32v  [3] = '{1'b0, 1'b0, 1'b1};
    logic [32:0] exp32 [3] = '{33'h1_0000_0000, 33'h0_9999_9999, 33'h1_0000_0000};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1;
        s8 = 0; a8 = '0; b8 = '0; c8 = 0;
        s1 = 0; a1 = 0;  b1 = 0;  c1 = 0;
        s32 = 0; a32 = '0; b32 = '0; c32 = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'b0, r8}, 64'd1);
        chk("rst_busy", {63'b0, bz8}, 64'd0);
        chk("rst_done", {63'b0, d8}, 64'd0);
        chk("rst_sum", {56'b0, sum8}, 64'd0);
        chk("rst_cout", {63'b0, co8}, 64'd0);
        rst = 1'b0;

        // Basic add with busy window and done-cycle flags
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; c8 = 0; s8 = 1'b1;
        sb.push_back('{8'h96, 1'b0, cyc + 9});
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) s8 = 1'b0;
            chk("run_busy", {63'b0, bz8}, 64'd1);
            chk("run_ready", {63'b0, r8}, 64'd0);
        end
        @(negedge clk);
        chk("done_busy", {63'b0, bz8}, 64'd0);
        chk("done_ready", {63'b0, r8}, 64'd1);
        chk("done_flag", {63'b0, d8}, 64'd1);
        drain(20);

        issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1); drain(20);
        issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1); drain(20);
        issue8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1); drain(20);
        issue8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0); drain(20);
        issue8(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1); drain(20);

        // Start while busy is ignored
        issue8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
        repeat (3) @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        drain(20);
        repeat (12) @(negedge clk);

        // Back-to-back start in the done cycle
        issue8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!d8 && k < 20);
        chk("b2b_first_done", {63'b0, d8}, 64'd1);
        a8 = 8'h01; b8 = 8'h02; c8 = 0; s8 = 1'b1;
        sb.push_back('{8'h03, 1'b0, cyc + 9});
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) s8 = 1'b0;
            chk("b2b_sum_hold", {56'b0, sum8}, 64'h30);
        end
        drain(20);

        // Reset mid-run
        issue8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_sum", {56'b0, sum8}, 64'd0);
        chk("mid_rst_cout", {63'b0, co8}, 64'd0);
        chk("mid_rst_ready", {63'b0, r8}, 64'd1);
        chk("mid_rst_busy", {63'b0, bz8}, 64'd0);
        repeat (12) @(negedge clk);
        issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        drain(20);

        // WIDTH=1: every operand combination, two-cycle latency
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; c1 = v[0]; s1 = 1'b1;
            @(negedge clk);
            s1 = 1'b0;
            chk("w1_busy", {63'b0, bz1}, 64'd1);
            @(negedge clk);
            chk("w1_done", {63'b0, d1}, 64'd1);
            chk("w1_result", {62'b0, co1, sum1}, {62'b0, exp1[i]});
        end

        // WIDTH=32: full-width carries, 33-cycle latency
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a32 = a32v[i]; b32 = b32v[i]; c32 = c32v[i]; s32 = 1'b1;
            k = 0;
            do begin
                @(negedge clk);
                k++;
                if (k == 1) s32 = 1'b0;
            end while (!d32 && k < 40);
            chk("w32_latency", 64'(k), 64'd33);
            chk("w32_result", {31'b0, co32, sum32}, {31'b0, exp32[i]});
        end

        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around a single one-bit full-adder cell. It accepts two WIDTH-bit operands and a carry-in on a start strobe. It then feeds the cell one bit pair per clock, LSB first, and recirculates the cell's carry through a flip-flop. It assembles the sum in a shift register and presents a registered WIDTH-bit result with carry-out. It trades latency for area next to the ripple adders in the arithmetic datapath.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- start  in  1  request a new addition; accepted only when ready=1.
- a  in  WIDTH  operand A; sampled only on an accepted start.
- b  in  WIDTH  operand B; sampled only on an accepted start.
- cin  in  1  carry-in; sampled only on an accepted start.
- ready  out  1  block can accept start (state IDLE or DONE).
- busy  out  1  addition in progress (state RUN).
- done  out  1  one-cycle pulse: sum/cout valid from this cycle.
- sum  out  WIDTH  registered result, held until next result.
- cout  out  1  registered carry-out, held with sum.

## Operation
- States: IDLE, RUN, DONE; encoding is free.
- IDLE behaviour:
  - ready=1, busy=0, done=0.
  - On start=1: load shift regA<=a, regB<=b, carry FF<=cin, bit counter<=0, partial sum reg<=0; go to RUN.
- RUN behaviour:
  - The full-adder cell sees regA[0], regB[0], carry FF.
  - Each cycle: shift the cell sum into partial sum MSB (shift right); carry FF<=cell carry; regA, regB shift right with 0 fill; counter+1.
  - When counter==WIDTH-1, this cycle's update is the last. Then sum<=completed partial sum, cout<=cell carry, and the state goes to DONE.
- DONE behaviour:
  - done=1, ready=1, busy=0 for exactly one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back), next state RUN. Otherwise go to IDLE.
- Ignored inputs: start while busy=1 is ignored; operands in regA/regB are not disturbed.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Output hold: sum/cout change only on the RUN->DONE transition or on reset.
- Counter width: $clog2(WIDTH) with a minimum of 1 bit.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing
- Start to busy: start accepted in cycle 0; busy=1 in cycles 1..WIDTH.
- Start to done: done=1 in cycle WIDTH+1. Total latency is WIDTH+1 cycles from start to valid result.
- Throughput: one addition per WIDTH+1 cycles with back-to-back starts.
- Reset values:
  - ready=1, busy=0, done=0.
  - sum=0, cout=0.
  - Internal regs 0, state IDLE.
- Reset mid-RUN: abort the addition; reset values appear the cycle after rst is sampled; no done pulse.
- Simultaneous start and rst: reset wins.
- Combinational paths: none from inputs to outputs; ready/busy/done decode directly from state registers.

## Structure
- Shared package:
  - Default WIDTH.
  - State enumeration (IDLE/RUN/DONE).
- Sub-module: one instance of the team's existing one-bit full-adder cell (fulladder, ports a, b, c, sum, carry). It is driven by regA[0], regB[0] and the carry FF. No other arithmetic is inferred.
- Top-level contents: FSM, bit counter, three shift registers, carry FF, output registers.

## Test plan
- Basic add: WIDTH=8, a=0x5A, b=0x3C, cin=0, start in cycle 0 -> done in cycle 9 only, sum=0x96, cout=0, busy high cycles 1..8.
- Carry-out and overflow:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start while busy: start pulsed with a=0x11, b=0x22 during cycle 4 of a 0x10+0x20 addition -> ignored; result 0x30, cout=0; no second done.
- Back-to-back: second start (a=0x01, b=0x02) held high in the done cycle -> accepted. sum stays 0x30 until the next done 9 cycles later, then becomes 0x03.
- Reset mid-run: rst in cycle 5 of an addition -> next cycle sum=0, cout=0, ready=1, busy=0; no done. A subsequent 0x7F+0x01 gives 0x80.
- Randomized check: WIDTH=1 and WIDTH=32 with 1000 random operands -> {cout,sum}==a+b+cin, done every WIDTH+1 cycles.
